airi5c_spi_arbiter: RTL
=======================

Name: airi5c_spi_arbiter

Overview:
Round-robin arbiter and burst sequencer that shares one SPI master datapath between NUM_REQ on-chip requesters. It grants one requester at a time and drives that requester's active-low slave select. It feeds the requester's tx words into the master one at a time, routes received words back, and inserts a programmable deselect gap between bursts. It sits between the requester ports (e.g. flash, sensor, debug) and the single SPI master instance inside the SPI peripheral.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, SPI word width
LEN_W, 8, width of burst length field (words-1)
CS_GAP, 4, clk cycles all ss_n held high between bursts (>=1)
TIMEOUT, 1024, clk cycles watchdog limit (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req  in  NUM_REQ  request per requester, held until done
len  in  NUM_REQ*LEN_W  per-requester burst length minus 1, slice i = bits [i*LEN_W +: LEN_W]
tx_data  in  NUM_REQ*DATA_WIDTH  per-requester tx word, slice i
tx_valid  in  NUM_REQ  tx word valid
tx_ready  out  NUM_REQ  one-hot, word accepted this cycle
rx_data  out  DATA_WIDTH  received word (shared)
rx_valid  out  NUM_REQ  one-hot 1-cycle pulse to granted requester
grant  out  NUM_REQ  one-hot, current owner
done  out  NUM_REQ  one-hot 1-cycle pulse at burst end
error  out  1  1-cycle timeout pulse (0 without optional feature)
m_start  out  1  1-cycle pulse: start one word on master
m_tx_data  out  DATA_WIDTH  word to master, valid with m_start
m_busy  in  1  master busy
m_rx_valid  in  1  1-cycle pulse, master word finished
m_rx_data  in  DATA_WIDTH  word from master
ss_n  out  NUM_REQ  active-low slave selects

Behaviour:
- All state on posedge clk; reset is synchronous, active-high, and takes priority in any state, including mid-burst.
- Reset values: grant=0, ss_n=all 1, tx_ready=0, rx_valid=0, done=0, error=0, m_start=0, m_tx_data=0, rx_data=0, state=IDLE, rr pointer=0.
- FSM states: IDLE, LOAD, XFER, GAP.
- IDLE:
  - If any req, pick the first set bit searching from rr pointer upward, wrapping modulo NUM_REQ.
  - Set grant=onehot(i) and ss_n[i]=0, latch len slice into cnt, move rr pointer to i+1 (wrap). Next state LOAD.
  - Grant appears in the cycle after req is sampled.
- LOAD:
  - Wait for tx_valid[i] && !m_busy.
  - In that cycle: tx_ready[i]=1 (combinational with the condition), latch tx_data slice into m_tx_data, pulse m_start next cycle. Next state XFER.
- XFER:
  - Wait for m_rx_valid. Register m_rx_data into rx_data and pulse rx_valid[i] in the next cycle.
  - If cnt==0 or req[i]==0: go to GAP and pulse done[i]. Otherwise cnt-=1 and go to LOAD.
  - A requester dropping req mid-burst therefore ends the burst after the in-flight word; words already started are never cut.
- GAP:
  - grant=0, ss_n all 1 for exactly CS_GAP cycles, then IDLE.
  - Requests are not evaluated during GAP.
- m_start is never asserted while m_busy=1 or outside LOAD->XFER.
- Exactly one m_start per word; exactly one rx_valid per m_rx_valid.
- m_rx_valid outside XFER is ignored.
- len=0 gives a 1-word burst; len=2^LEN_W-1 gives 2^LEN_W words. cnt never underflows.
- Simultaneous req: only one grant; the others wait. Starvation-free: worst-case wait is NUM_REQ-1 bursts.
- Only one bit of grant, ss_n(low), tx_ready, rx_valid or done is ever active.

Optional Feature:
Macro SPI_ARB_TIMEOUT_EN.
- With it: a cycle counter runs in LOAD and XFER, cleared on every state change. If it reaches TIMEOUT:
  - pulse error for 1 cycle and pulse done[i];
  - go to GAP; no m_start is issued afterwards.
  - In XFER the master word may still finish; its later m_rx_valid is ignored.
- Without it: no counter; error tied 0; LOAD and XFER wait indefinitely.

Test Plan:
- Reset then req=0001, len0=2, tx words 0xA5,0x5A,0xFF, master loops m_rx_data=~m_tx_data -> 3 m_start pulses; rx_valid[0] with 0x5A,0xA5,0x00; ss_n=1110 throughout; done[0] once; then ss_n=1111 for 4 cycles.
- req=1111 held, len all 0 -> grants in order 0,1,2,3,0; each grant separated by >=CS_GAP cycles of ss_n=1111.
- req[2] alone, len=5, drop req after 2nd rx_valid -> exactly 2 words transferred, done[2] pulses, GAP entered.
- m_busy held 1 for 10 cycles while in LOAD with tx_valid=1 -> no m_start and no tx_ready until m_busy=0, then exactly one m_start.
- reset asserted in XFER mid-burst -> next cycle ss_n=1111, grant=0, no rx_valid or done pulses; a subsequent req[1] is granted normally.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT=16, req[3] with tx_valid=0 -> error and done[3] pulse after 16 cycles in LOAD, ss_n=1111, no m_start; without the macro: stays in LOAD, error=0.

Source files
------------

// File: rtl/airi5c_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters, with per-requester
// slave selects and a deselect gap between bursts. Define SPI_ARB_TIMEOUT_EN for the watchdog.
module airi5c_spi_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
  input  logic [NUM_REQ-1:0]            tx_valid,
  output logic [NUM_REQ-1:0]            tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic [NUM_REQ-1:0]            rx_valid,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          error,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  input  logic                          m_busy,
  input  logic                          m_rx_valid,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  output logic [NUM_REQ-1:0]            ss_n
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StXfer, StGap} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, rr_q, rr_d, pick_idx;
  logic                  pick_valid;
  logic [NUM_REQ-1:0]    grant_q, grant_d, rx_valid_q, rx_valid_d, done_q, done_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] m_tx_data_q, m_tx_data_d, rx_data_q, rx_data_d;
  logic                  m_start_q, m_start_d;
  int unsigned           cand;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             error_q, error_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`endif

  // First requester at or above the round-robin pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!pick_valid && req[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    m_tx_data_d = m_tx_data_q;
    rx_data_d   = rx_data_q;
    m_start_d   = 1'b0;
    rx_valid_d  = '0;
    done_d      = '0;
    tx_ready    = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    error_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          cnt_d   = len[pick_idx*LEN_W +: LEN_W];
          rr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (tx_valid[idx_q] && !m_busy) begin
          tx_ready    = grant_q;
          m_tx_data_d = tx_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
          m_start_d   = 1'b1;
          state_d     = StXfer;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          gap_d   = GAP_W'(CS_GAP - 1);
          state_d = StGap;
        end
`endif
      end
      StXfer: begin
        if (m_rx_valid) begin
          rx_data_d  = m_rx_data;
          rx_valid_d = grant_q;
          // A dropped request ends the burst once the in-flight word is back.
          if (cnt_q == '0 || !req[idx_q]) begin
            done_d  = grant_q;
            grant_d = '0;
            gap_d   = GAP_W'(CS_GAP - 1);
            state_d = StGap;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = StLoad;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          gap_d   = GAP_W'(CS_GAP - 1);
          state_d = StGap;
        end
`endif
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d = ((state_q == StLoad || state_q == StXfer) && state_d == state_q) ? tmo_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      m_tx_data_q <= '0;
      rx_data_q   <= '0;
      m_start_q   <= 1'b0;
      rx_valid_q  <= '0;
      done_q      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      m_tx_data_q <= m_tx_data_d;
      rx_data_q   <= rx_data_d;
      m_start_q   <= m_start_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      error_q     <= error_d;
`endif
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign error = 1'b0;
`endif

  assign grant     = grant_q;
  assign ss_n      = ~grant_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = done_q;
  assign m_start   = m_start_q;
  assign m_tx_data = m_tx_data_q;

endmodule
